// File: rtl/pipeline_flow_controller.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_flow_controller
// Purpose  : Run/halt/single-step/flush sequencer driving global stall/flush.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_flow_controller #(
  parameter int STEP_W       = 16,
  parameter int FLUSH_CYCLES = 4,
  parameter bit START_HALTED = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt_req_i,
  input  logic              resume_req_i,
  input  logic              step_req_i,
  input  logic [STEP_W-1:0] step_count_i,
  input  logic              flush_req_i,
  input  logic              break_i,
  output logic              global_stall_o,
  output logic              global_flush_o,
  output logic              halted_o,
  output logic              step_done_o,
  output logic [31:0]       cycles_run_o
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_HALTED = 2'd1,
    S_STEP   = 2'd2,
    S_FLUSH  = 2'd3
  } state_t;

  localparam state_t            c_RESET_STATE = START_HALTED ? S_HALTED : S_RUN;
  localparam logic [7:0]        c_FLUSH_LOAD  = 8'(FLUSH_CYCLES);
  localparam logic [STEP_W-1:0] c_STEP_ONE    = STEP_W'(1);

  state_t              r_state;
  state_t              w_next_state;
  logic                r_ret_halted;
  logic                w_next_ret_halted;
  logic [STEP_W-1:0]   r_step_cnt;
  logic [STEP_W-1:0]   w_next_step_cnt;
  logic [7:0]          r_flush_cnt;
  logic [7:0]          w_next_flush_cnt;
  logic                r_stall;
  logic                r_flush;
  logic                r_halted;
  logic                r_step_done;
  logic [31:0]         r_cycles_run;
  logic                w_advance;

  always_comb begin
    w_next_state      = r_state;
    w_next_ret_halted = r_ret_halted;
    w_next_step_cnt   = r_step_cnt;
    w_next_flush_cnt  = r_flush_cnt;
    case (r_state)
      S_RUN: begin
        if (flush_req_i) begin
          w_next_state      = S_FLUSH;
          w_next_ret_halted = 1'b0;
          w_next_flush_cnt  = c_FLUSH_LOAD;
        end else if (halt_req_i || break_i) begin
          w_next_state = S_HALTED;
        end
      end
      S_HALTED: begin
        if (flush_req_i) begin
          w_next_state      = S_FLUSH;
          w_next_ret_halted = 1'b1;
          w_next_flush_cnt  = c_FLUSH_LOAD;
        end else if (step_req_i) begin
          w_next_state    = S_STEP;
          w_next_step_cnt = (step_count_i == '0) ? c_STEP_ONE : step_count_i;
        end else if (resume_req_i && !halt_req_i) begin
          w_next_state = S_RUN;
        end
      end
      S_STEP: begin
        w_next_step_cnt = r_step_cnt - c_STEP_ONE;
        if (flush_req_i) begin
          w_next_state      = S_FLUSH;
          w_next_ret_halted = 1'b1;
          w_next_flush_cnt  = c_FLUSH_LOAD;
        end else if (halt_req_i || break_i || (r_step_cnt == c_STEP_ONE)) begin
          w_next_state = S_HALTED;
        end
      end
      S_FLUSH: begin
        // Pulse requests are deliberately not looked at while flushing.
        w_next_flush_cnt = r_flush_cnt - 8'd1;
        if (r_flush_cnt == 8'd1) begin
          w_next_state = r_ret_halted ? S_HALTED : S_RUN;
        end
      end
      default: begin
        w_next_state = S_HALTED;
      end
    endcase
  end

  assign w_advance = !r_stall && !r_flush;

  // Outputs are decoded from the next state and registered so they leave flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_RESET_STATE;
      r_ret_halted <= 1'b1;
      r_step_cnt   <= '0;
      r_flush_cnt  <= '0;
      r_stall      <= START_HALTED;
      r_flush      <= 1'b0;
      r_halted     <= START_HALTED;
      r_step_done  <= 1'b0;
      r_cycles_run <= '0;
    end else begin
      r_state      <= w_next_state;
      r_ret_halted <= w_next_ret_halted;
      r_step_cnt   <= w_next_step_cnt;
      r_flush_cnt  <= w_next_flush_cnt;
      r_stall      <= (w_next_state == S_HALTED);
      r_flush      <= (w_next_state == S_FLUSH);
      r_halted     <= (w_next_state == S_HALTED);
      r_step_done  <= (r_state == S_STEP) && (w_next_state == S_HALTED);
      if (w_advance) begin
        r_cycles_run <= r_cycles_run + 32'd1;
      end
    end
  end

  assign global_stall_o = r_stall;
  assign global_flush_o = r_flush;
  assign halted_o       = r_halted;
  assign step_done_o    = r_step_done;
  assign cycles_run_o   = r_cycles_run;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_flow_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_flow_controller
// Purpose  : Self-checking bench for pipeline_flow_controller (scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_flow_controller;

  localparam int STEP_W       = 16;
  localparam int FLUSH_CYCLES = 4;

  // Expected output vector {stall, flush, halted, step_done}
  localparam logic [3:0] O_RUN   = 4'b0000;
  localparam logic [3:0] O_HALT  = 4'b1010;
  localparam logic [3:0] O_DONE  = 4'b1011;
  localparam logic [3:0] O_FLUSH = 4'b0100;

  // Request vector {halt, resume, step, flush, break}
  localparam logic [4:0] I_NONE  = 5'b00000;
  localparam logic [4:0] I_HALT  = 5'b10000;
  localparam logic [4:0] I_RES   = 5'b01000;
  localparam logic [4:0] I_STEP  = 5'b00100;
  localparam logic [4:0] I_FLUSH = 5'b00010;
  localparam logic [4:0] I_BRK   = 5'b00001;

  typedef struct packed {
    logic [3:0]  o;
    logic [31:0] c;
  } exp_t;

  typedef struct packed {
    logic [4:0]  req;
    logic [15:0] cnt;
    logic [3:0]  o;
  } row_t;

  logic              clk;
  logic              rst_n;
  logic              halt_req_i;
  logic              resume_req_i;
  logic              step_req_i;
  logic [STEP_W-1:0] step_count_i;
  logic              flush_req_i;
  logic              break_i;
  logic              global_stall_o;
  logic              global_flush_o;
  logic              halted_o;
  logic              step_done_o;
  logic [31:0]       cycles_run_o;
  logic [3:0]        obs;

  exp_t        sb[$];
  int          n_tests;
  int          n_fail;
  logic [31:0] m_cyc;
  logic [3:0]  m_cur;

  pipeline_flow_controller #(
    .STEP_W       (STEP_W),
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .START_HALTED (1'b1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .halt_req_i     (halt_req_i),
    .resume_req_i   (resume_req_i),
    .step_req_i     (step_req_i),
    .step_count_i   (step_count_i),
    .flush_req_i    (flush_req_i),
    .break_i        (break_i),
    .global_stall_o (global_stall_o),
    .global_flush_o (global_flush_o),
    .halted_o       (halted_o),
    .step_done_o    (step_done_o),
    .cycles_run_o   (cycles_run_o)
  );

  assign obs = {global_stall_o, global_flush_o, halted_o, step_done_o};

  always #5 clk = ~clk;

  // Drive one cycle of requests at a falling edge and queue the expected result.
  task automatic drive_row(input row_t r);
    {halt_req_i, resume_req_i, step_req_i, flush_req_i, break_i} = r.req;
    step_count_i = r.cnt;
    if (m_cur[3:2] == 2'b00) m_cyc = m_cyc + 32'd1;
    m_cur = r.o;
    sb.push_back('{o: r.o, c: m_cyc});
    @(negedge clk);
  endtask

  task automatic test_reset();
    row_t rows[8] = '{
      '{I_NONE, 16'd0, O_HALT}, '{I_NONE, 16'd0, O_HALT},
      '{I_RES,  16'd0, O_RUN},  '{I_NONE, 16'd0, O_RUN},
      '{I_NONE, 16'd0, O_RUN},  '{I_NONE, 16'd0, O_RUN},
      '{I_HALT, 16'd0, O_HALT}, '{I_NONE, 16'd0, O_HALT}
    };
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (obs !== O_HALT || cycles_run_o !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_values: got o=%b c=%h, expected o=%b c=%h", obs, cycles_run_o, O_HALT, 32'd0);
    end
    rst_n = 1'b1;
    m_cur = O_HALT;
    m_cyc = 32'd0;
    foreach (rows[i]) begin
      exp_t e;
      drive_row(rows[i]);
      e = sb.pop_front();
      n_tests++;
      if (obs !== e.o || cycles_run_o !== e.c) begin
        n_fail++;
        $display("FAIL reset_resume row%0d: got o=%b c=%h, expected o=%b c=%h", i, obs, cycles_run_o, e.o, e.c);
      end
    end
  endtask

  task automatic test_step();
    row_t rows[8] = '{
      '{I_STEP, 16'd3, O_RUN},  '{I_RES,  16'd0, O_RUN},
      '{I_STEP, 16'd7, O_RUN},  '{I_NONE, 16'd0, O_DONE},
      '{I_NONE, 16'd0, O_HALT}, '{I_STEP, 16'd0, O_RUN},
      '{I_NONE, 16'd0, O_DONE}, '{I_NONE, 16'd0, O_HALT}
    };
    foreach (rows[i]) begin
      exp_t e;
      drive_row(rows[i]);
      e = sb.pop_front();
      n_tests++;
      if (obs !== e.o || cycles_run_o !== e.c) begin
        n_fail++;
        $display("FAIL single_step row%0d: got o=%b c=%h, expected o=%b c=%h", i, obs, cycles_run_o, e.o, e.c);
      end
    end
  endtask

  task automatic test_step_abort();
    row_t rows[7] = '{
      '{I_STEP, 16'd10, O_RUN}, '{I_NONE, 16'd0, O_RUN},
      '{I_NONE, 16'd0, O_RUN},  '{I_NONE, 16'd0, O_RUN},
      '{I_BRK,  16'd0, O_DONE}, '{I_BRK,  16'd0, O_HALT},
      '{I_NONE, 16'd0, O_HALT}
    };
    foreach (rows[i]) begin
      exp_t e;
      drive_row(rows[i]);
      e = sb.pop_front();
      n_tests++;
      if (obs !== e.o || cycles_run_o !== e.c) begin
        n_fail++;
        $display("FAIL step_abort row%0d: got o=%b c=%h, expected o=%b c=%h", i, obs, cycles_run_o, e.o, e.c);
      end
    end
  endtask

  task automatic test_flush();
    row_t rows[7] = '{
      '{I_RES,   16'd0, O_RUN},   '{I_FLUSH, 16'd0, O_FLUSH},
      '{I_RES,   16'd0, O_FLUSH}, '{I_STEP,  16'd5, O_FLUSH},
      '{I_FLUSH, 16'd0, O_FLUSH}, '{I_NONE,  16'd0, O_RUN},
      '{I_HALT,  16'd0, O_HALT}
    };
    foreach (rows[i]) begin
      exp_t e;
      drive_row(rows[i]);
      e = sb.pop_front();
      n_tests++;
      if (obs !== e.o || cycles_run_o !== e.c) begin
        n_fail++;
        $display("FAIL flush row%0d: got o=%b c=%h, expected o=%b c=%h", i, obs, cycles_run_o, e.o, e.c);
      end
    end
  endtask

  task automatic test_simultaneous();
    row_t rows[16] = '{
      '{I_FLUSH | I_STEP | I_RES, 16'd2, O_FLUSH},
      '{I_NONE, 16'd0, O_FLUSH}, '{I_NONE, 16'd0, O_FLUSH},
      '{I_NONE, 16'd0, O_FLUSH}, '{I_NONE, 16'd0, O_HALT},
      '{I_HALT | I_RES, 16'd0, O_HALT}, '{I_HALT, 16'd0, O_HALT},
      '{I_RES,  16'd0, O_RUN},
      '{I_FLUSH | I_HALT, 16'd0, O_FLUSH},
      '{I_HALT, 16'd0, O_FLUSH}, '{I_HALT, 16'd0, O_FLUSH},
      '{I_HALT, 16'd0, O_FLUSH}, '{I_HALT, 16'd0, O_RUN},
      '{I_HALT, 16'd0, O_HALT},  '{I_RES,  16'd0, O_RUN},
      '{I_BRK,  16'd0, O_HALT}
    };
    foreach (rows[i]) begin
      exp_t e;
      drive_row(rows[i]);
      e = sb.pop_front();
      n_tests++;
      if (obs !== e.o || cycles_run_o !== e.c) begin
        n_fail++;
        $display("FAIL simultaneous row%0d: got o=%b c=%h, expected o=%b c=%h", i, obs, cycles_run_o, e.o, e.c);
      end
    end
  endtask

  task automatic test_wrap();
    row_t rows[4] = '{
      '{I_RES,  16'd0, O_RUN}, '{I_NONE, 16'd0, O_RUN},
      '{I_NONE, 16'd0, O_RUN}, '{I_HALT, 16'd0, O_HALT}
    };
    force dut.r_cycles_run = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.r_cycles_run;
    @(negedge clk);
    m_cyc = 32'hFFFF_FFFE;
    n_tests++;
    if (cycles_run_o !== 32'hFFFF_FFFE) begin
      n_fail++;
      $display("FAIL wrap_preload: got c=%h, expected c=%h", cycles_run_o, 32'hFFFF_FFFE);
    end
    foreach (rows[i]) begin
      exp_t e;
      drive_row(rows[i]);
      e = sb.pop_front();
      n_tests++;
      if (obs !== e.o || cycles_run_o !== e.c) begin
        n_fail++;
        $display("FAIL wrap row%0d: got o=%b c=%h, expected o=%b c=%h", i, obs, cycles_run_o, e.o, e.c);
      end
    end
  endtask

  task automatic test_reset_mid_step();
    row_t rows[3] = '{
      '{I_STEP, 16'd10, O_RUN}, '{I_NONE, 16'd0, O_RUN}, '{I_NONE, 16'd0, O_RUN}
    };
    row_t post[2] = '{
      '{I_NONE, 16'd0, O_HALT}, '{I_NONE, 16'd0, O_HALT}
    };
    foreach (rows[i]) begin
      exp_t e;
      drive_row(rows[i]);
      e = sb.pop_front();
      n_tests++;
      if (obs !== e.o || cycles_run_o !== e.c) begin
        n_fail++;
        $display("FAIL mid_step row%0d: got o=%b c=%h, expected o=%b c=%h", i, obs, cycles_run_o, e.o, e.c);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (obs !== O_HALT || cycles_run_o !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset: got o=%b c=%h, expected o=%b c=%h", obs, cycles_run_o, O_HALT, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_cur = O_HALT;
    m_cyc = 32'd0;
    foreach (post[i]) begin
      exp_t e;
      drive_row(post[i]);
      e = sb.pop_front();
      n_tests++;
      if (obs !== e.o || cycles_run_o !== e.c) begin
        n_fail++;
        $display("FAIL post_reset row%0d: got o=%b c=%h, expected o=%b c=%h", i, obs, cycles_run_o, e.o, e.c);
      end
    end
  endtask

  initial begin
    clk          = 1'b0;
    rst_n        = 1'b0;
    halt_req_i   = 1'b0;
    resume_req_i = 1'b0;
    step_req_i   = 1'b0;
    step_count_i = '0;
    flush_req_i  = 1'b0;
    break_i      = 1'b0;
    n_tests      = 0;
    n_fail       = 0;
    m_cyc        = 32'd0;
    m_cur        = O_HALT;

    test_reset();
    test_step();
    test_step_abort();
    test_flush();
    test_simultaneous();
    test_wrap();
    test_reset_mid_step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
